bpu_update_queue: RTL

// Receiving end of the registered branch-unit predictor-update fields leaving the int writeback stage.

---
 rtl/bpu_update_queue.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bpu_update_queue.sv
// bpu_update_queue: buffers BHT/BTB training writes from the int writeback stage
// and drains them into the predictor arrays whenever the frontend read port is idle.
// Upstream cannot stall, so a request that finds the queue full is counted as dropped.

`ifndef BHTBTB_INDEX_WIDTH
`define BHTBTB_INDEX_WIDTH 8
`endif

module bpu_update_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BHT_IDX_W = `BHTBTB_INDEX_WIDTH,
    parameter int unsigned BTB_IDX_W = 9,
    parameter int unsigned BTB_W     = 129,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned PTR_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_bht_we,
    input  logic [BHT_IDX_W-1:0] in_bht_index,
    input  logic [1:0]           in_bht_sel,
    input  logic                 in_bht_inc,
    input  logic                 in_bht_dec,
    input  logic                 in_bht_valid,
    input  logic                 in_btb_ce,
    input  logic                 in_btb_we,
    input  logic [BTB_W-1:0]     in_btb_wmask,
    input  logic [BTB_IDX_W-1:0] in_btb_index,
    input  logic [BTB_W-1:0]     in_btb_din,
    input  logic                 bpu_read_busy,
    input  logic                 flush_queue,
    output logic                 out_bht_we,
    output logic [BHT_IDX_W-1:0] out_bht_index,
    output logic [1:0]           out_bht_sel,
    output logic                 out_bht_inc,
    output logic                 out_bht_dec,
    output logic                 out_bht_valid,
    output logic                 out_btb_ce,
    output logic                 out_btb_we,
    output logic [BTB_W-1:0]     out_btb_wmask,
    output logic [BTB_IDX_W-1:0] out_btb_index,
    output logic [BTB_W-1:0]     out_btb_din,
    output logic [PTR_W-1:0]     q_count,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 overflow_sticky
);

    typedef struct packed {
        logic                 bht_we;
        logic [BHT_IDX_W-1:0] bht_index;
        logic [1:0]           bht_sel;
        logic                 bht_inc;
        logic                 bht_dec;
        logic                 bht_valid;
        logic                 btb_ce;
        logic                 btb_we;
        logic [BTB_W-1:0]     btb_wmask;
        logic [BTB_IDX_W-1:0] btb_index;
        logic [BTB_W-1:0]     btb_din;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             in_entry;
    entry_t             out_q, out_d;
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               sticky_q, sticky_d;
    logic               enq, deq, push, drop, empty, full;

    // Pack the incoming request; a half that is not being written carries zero enables.
    always_comb begin
        in_entry.bht_we    = in_bht_we;
        in_entry.bht_index = in_bht_index;
        in_entry.bht_sel   = in_bht_sel;
        in_entry.bht_inc   = in_bht_inc;
        in_entry.bht_dec   = in_bht_dec;
        in_entry.bht_valid = in_bht_valid;
        in_entry.btb_ce    = in_btb_ce & in_btb_we;
        in_entry.btb_we    = in_btb_ce & in_btb_we;
        in_entry.btb_wmask = in_btb_wmask;
        in_entry.btb_index = in_btb_index;
        in_entry.btb_din   = in_btb_din;
    end

    // Queue control: a full queue still accepts when the head leaves the same cycle.
    always_comb begin
        enq   = in_bht_we | (in_btb_ce & in_btb_we);
        empty = (wr_q == rd_q);
        full  = (wr_q[PTR_W-2:0] == rd_q[PTR_W-2:0]) && (wr_q[PTR_W-1] != rd_q[PTR_W-1]);
        deq   = !empty && !bpu_read_busy && !flush_queue;
        push  = enq && !flush_queue && (!full || deq);
        drop  = enq && !flush_queue && full && !deq;
    end

    // Next-state for pointers, occupancy, drop accounting and the output register.
    always_comb begin
        wr_d          = wr_q;
        rd_d          = rd_q;
        count_d       = count_q;
        drop_d        = drop_q;
        sticky_d      = sticky_q;
        out_d         = out_q;
        out_d.bht_we  = 1'b0;
        out_d.btb_ce  = 1'b0;
        out_d.btb_we  = 1'b0;
        if (flush_queue) begin
            rd_d    = wr_q;
            count_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + 1'b1;
            end
            if (deq) begin
                rd_d  = rd_q + 1'b1;
                out_d = mem_q[rd_q[PTR_W-2:0]];
            end
            case ({push, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (drop) begin
            sticky_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    // State registers; reset clears everything including any pending output pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            sticky_q <= 1'b0;
            out_q    <= '0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            sticky_q <= sticky_d;
            out_q    <= out_d;
        end
    end

    // Entry storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_q[PTR_W-2:0]] <= in_entry;
        end
    end

    assign out_bht_we      = out_q.bht_we;
    assign out_bht_index   = out_q.bht_index;
    assign out_bht_sel     = out_q.bht_sel;
    assign out_bht_inc     = out_q.bht_inc;
    assign out_bht_dec     = out_q.bht_dec;
    assign out_bht_valid   = out_q.bht_valid;
    assign out_btb_ce      = out_q.btb_ce;
    assign out_btb_we      = out_q.btb_we;
    assign out_btb_wmask   = out_q.btb_wmask;
    assign out_btb_index   = out_q.btb_index;
    assign out_btb_din     = out_q.btb_din;
    assign q_count         = count_q;
    assign drop_cnt        = drop_q;
    assign overflow_sticky = sticky_q;

endmodule
